// File: rtl/scan_unstuffer.sv
// rtl/scan_unstuffer.sv - JPEG scan byte unstuffer: strips FF00 stuffing, fill bytes and markers.
// Optional RSTn sequence checking is enabled by defining RST_CHECK_EN (adds rst_seq_err).
module scan_unstuffer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rst_seen,
    output logic [2:0]       rst_idx,
    output logic             eoi,
    output logic             marker_err,
    output logic             scan_done,
    output logic [CNT_W-1:0] byte_cnt
`ifdef RST_CHECK_EN
    ,
    output logic             rst_seq_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DATA    = 2'd1,
        S_FF_SEEN = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q;
    logic [CNT_W-1:0] byte_cnt_q;
    logic             rst_seen_q, rst_seen_d;
    logic [2:0]       rst_idx_q, rst_idx_d;
    logic             eoi_q, eoi_d;
    logic             marker_err_q, marker_err_d;
    logic             push;
    logic [7:0]       push_byte;
    logic             pop;
    logic             accept;
    logic             in_active;

    // in_ready never looks at out_ready: a full FIFO stalls even if it drains this cycle.
    assign in_active = (state_q == S_DATA) || (state_q == S_FF_SEEN);
    assign in_ready  = in_active && (count_q != 2'd2) && !scan_start;
    assign accept    = in_valid && in_ready;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;

    assign rst_seen   = rst_seen_q;
    assign rst_idx    = rst_idx_q;
    assign eoi        = eoi_q;
    assign marker_err = marker_err_q;
    assign scan_done  = (state_q == S_DONE);
    assign byte_cnt   = byte_cnt_q;

    always_comb begin
        state_d      = state_q;
        push         = 1'b0;
        push_byte    = in_data;
        rst_seen_d   = 1'b0;
        rst_idx_d    = rst_idx_q;
        eoi_d        = 1'b0;
        marker_err_d = 1'b0;
        if (scan_start) begin
            state_d = S_DATA;
        end else if (accept) begin
            case (state_q)
                S_DATA: begin
                    if (in_data == 8'hFF) state_d = S_FF_SEEN;
                    else                  push    = 1'b1;
                end
                S_FF_SEEN: begin
                    if (in_data == 8'h00) begin
                        push      = 1'b1;
                        push_byte = 8'hFF;
                        state_d   = S_DATA;
                    end else if (in_data == 8'hFF) begin
                        state_d = S_FF_SEEN;
                    end else if (in_data[7:3] == 5'b11010) begin
                        rst_seen_d = 1'b1;
                        rst_idx_d  = in_data[2:0];
                        state_d    = S_DATA;
                    end else if (in_data == 8'hD9) begin
                        eoi_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        marker_err_d = 1'b1;
                        state_d      = S_DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mem_q[0]     <= 8'h00;
            mem_q[1]     <= 8'h00;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            byte_cnt_q   <= '0;
            rst_seen_q   <= 1'b0;
            rst_idx_q    <= 3'd0;
            eoi_q        <= 1'b0;
            marker_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_seen_q   <= rst_seen_d;
            rst_idx_q    <= rst_idx_d;
            eoi_q        <= eoi_d;
            marker_err_q <= marker_err_d;
            if (scan_start) begin
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
                count_q    <= 2'd0;
                byte_cnt_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= push_byte;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q   <= ~rd_ptr_q;
                    byte_cnt_q <= byte_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

`ifdef RST_CHECK_EN
    logic [2:0] exp_idx_q;
    logic       rst_seq_err_q;

    assign rst_seq_err = rst_seq_err_q;

    // The expected index resyncs to whatever arrived, so one bad RSTn flags only once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_idx_q     <= 3'd0;
            rst_seq_err_q <= 1'b0;
        end else begin
            rst_seq_err_q <= 1'b0;
            if (scan_start) begin
                exp_idx_q <= 3'd0;
            end else if (rst_seen_d) begin
                rst_seq_err_q <= (rst_idx_d != exp_idx_q);
                exp_idx_q     <= rst_idx_d + 3'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scan_unstuffer.sv
// tb/tb_scan_unstuffer.sv - self-checking bench for scan_unstuffer with a stream-level reference model.
module tb_scan_unstuffer;

    typedef logic [7:0] u8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        rst_seen;
    logic [2:0]  rst_idx;
    logic        eoi;
    logic        marker_err;
    logic        scan_done;
    logic [15:0] byte_cnt;
`ifdef RST_CHECK_EN
    logic        rst_seq_err;
`endif

    int checks = 0;
    int errors = 0;

    u8  q_got[$];
    int ev_got[$];
    bit seq_got[$];
    u8  st[$];

    always #5 clk = ~clk;

    scan_unstuffer #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_start (scan_start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rst_seen   (rst_seen),
        .rst_idx    (rst_idx),
        .eoi        (eoi),
        .marker_err (marker_err),
        .scan_done  (scan_done),
        .byte_cnt   (byte_cnt)
`ifdef RST_CHECK_EN
        ,
        .rst_seq_err(rst_seq_err)
`endif
    );

    // Handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) q_got.push_back(out_data);
            if (rst_seen)   ev_got.push_back(int'(rst_idx));
            if (eoi)        ev_got.push_back(8);
            if (marker_err) ev_got.push_back(9);
`ifdef RST_CHECK_EN
            if (rst_seen)   seq_got.push_back(rst_seq_err);
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"},   32'(in_ready),   0);
        chk({tag, " out_valid"},  32'(out_valid),  0);
        chk({tag, " out_data"},   32'(out_data),   0);
        chk({tag, " rst_seen"},   32'(rst_seen),   0);
        chk({tag, " rst_idx"},    32'(rst_idx),    0);
        chk({tag, " eoi"},        32'(eoi),        0);
        chk({tag, " marker_err"}, 32'(marker_err), 0);
        chk({tag, " scan_done"},  32'(scan_done),  0);
        chk({tag, " byte_cnt"},   32'(byte_cnt),   0);
    endtask

    // Reference: walk the byte stream with lookahead over FF runs.
    // Events: 0..7 = RSTn index, 8 = EOI, 9 = bad marker.
    task automatic model(input u8 s[$], output u8 eo[$], output int ee[$],
                         output bit es[$], output bit done);
        int i;
        int j;
        int n;
        int expn;
        u8  m;
        i = 0; expn = 0; done = 0;
        eo.delete(); ee.delete(); es.delete();
        while (i < s.size() && !done) begin
            if (s[i] != 8'hFF) begin
                eo.push_back(s[i]);
                i++;
            end else begin
                j = i + 1;
                while (j < s.size() && s[j] == 8'hFF) j++;
                if (j >= s.size()) break;
                m = s[j];
                i = j + 1;
                if (m == 8'h00) begin
                    eo.push_back(8'hFF);
                end else if (m >= 8'hD0 && m <= 8'hD7) begin
                    n = int'(m) - 'hD0;
                    ee.push_back(n);
                    es.push_back(n != expn);
                    expn = (n + 1) % 8;
                end else if (m == 8'hD9) begin
                    ee.push_back(8);
                    done = 1;
                end else begin
                    ee.push_back(9);
                    done = 1;
                end
            end
        end
    endtask

    task automatic gen(output u8 s[$]);
        int n;
        int r;
        s.delete();
        n = $urandom_range(3, 14);
        repeat (n) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                s.push_back(u8'($urandom_range(0, 254)));
            end else if (r < 72) begin
                s.push_back(8'hFF); s.push_back(8'h00);
            end else if (r < 82) begin
                s.push_back(8'hFF); s.push_back(8'hFF);
                if ($urandom_range(0, 1) == 1) s.push_back(8'hFF);
                s.push_back(u8'(8'hD0 + $urandom_range(0, 7)));
            end else begin
                s.push_back(8'hFF);
                s.push_back(u8'(8'hD0 + $urandom_range(0, 7)));
            end
        end
        r = $urandom_range(0, 3);
        if (r != 0) s.push_back(8'hFF);
        if (r == 1 || r == 2) s.push_back(8'hD9);
        if (r == 3) begin
            case ($urandom_range(0, 5))
                0: s.push_back(8'hC4);
                1: s.push_back(8'hD8);
                2: s.push_back(8'hDA);
                3: s.push_back(8'hE0);
                4: s.push_back(8'h01);
                default: s.push_back(8'hFE);
            endcase
        end
        s.push_back(u8'($urandom_range(0, 255)));
        s.push_back(u8'($urandom_range(0, 255)));
    endtask

    // mode 0: always valid/ready; 1: random handshakes; 2: out_ready held low for 10 cycles.
    task automatic run_stream(input string name, input u8 s[$], input int mode);
        u8  eo[$];
        int ee[$];
        bit es[$];
        bit done;
        int idx;
        int cyc;
        bit lat;
        model(s, eo, ee, es, done);
        idx = 0; cyc = 0; lat = 0;
        @(posedge clk); #1;
        in_valid = 0; out_ready = 0; scan_start = 1;
        @(posedge clk); #1;
        scan_start = 0;
        q_got.delete(); ev_got.delete(); seq_got.delete();
        chk({name, " cnt_clear"}, 32'(byte_cnt), 0);
        chk({name, " flushed"},   32'(out_valid), 0);
        while (idx < s.size() && scan_done !== 1'b1 && cyc < 2000) begin
            in_data   = s[idx];
            in_valid  = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = (mode == 0) ? 1'b1 :
                        (mode == 1) ? ($urandom_range(0, 2) != 0) : (cyc >= 10);
            @(negedge clk);
            if (lat) begin
                chk({name, " latency_n1"}, 32'(out_valid), 1);
                lat = 0;
            end
            if (mode == 0 && idx == 0 && in_valid && in_ready && s[0] != 8'hFF) begin
                chk({name, " latency_n0"}, 32'(out_valid), 0);
                lat = 1;
            end
            if (mode == 2 && cyc == 10) begin
                chk({name, " accepted_while_stalled"}, 32'(idx), 2);
                chk({name, " no_passthrough"}, 32'(in_ready), 0);
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " timeout"}, 32'(cyc < 2000), 1);
        in_valid  = done;
        in_data   = 8'hAA;
        out_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        chk({name, " scan_done"}, 32'(scan_done), 32'(done));
        if (done) chk({name, " ignore_after_done"}, 32'(in_ready), 0);
        chk({name, " out_count"}, 32'(q_got.size()), 32'(eo.size()));
        for (int k = 0; k < eo.size() && k < q_got.size(); k++)
            chk($sformatf("%s out[%0d]", name, k), 32'(q_got[k]), 32'(eo[k]));
        chk({name, " byte_cnt"}, 32'(byte_cnt), 32'(eo.size()));
        chk({name, " ev_count"}, 32'(ev_got.size()), 32'(ee.size()));
        for (int k = 0; k < ee.size() && k < ev_got.size(); k++)
            chk($sformatf("%s ev[%0d]", name, k), 32'(ev_got[k]), 32'(ee[k]));
`ifdef RST_CHECK_EN
        chk({name, " seq_count"}, 32'(seq_got.size()), 32'(es.size()));
        for (int k = 0; k < es.size() && k < seq_got.size(); k++)
            chk($sformatf("%s seq_err[%0d]", name, k), 32'(seq_got[k]), 32'(es[k]));
`endif
        in_valid = 0;
    endtask

    initial begin
        rst_n = 0; scan_start = 0; in_data = 8'h00; in_valid = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1;
        in_valid = 1;
        @(posedge clk); #1;
        chk("idle in_ready", 32'(in_ready), 0);
        chk("idle no_accept", 32'(out_valid), 0);
        in_valid = 0;

        st = '{8'h12, 8'hFF, 8'h00, 8'h34, 8'hFF, 8'hD9};
        run_stream("eoi_basic", st, 0);
        st = '{8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hD3, 8'hBB};
        run_stream("fill_rst", st, 0);
        st = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_stream("backpressure", st, 2);
        st = '{8'h55, 8'hFF, 8'hC4, 8'h66, 8'h77};
        run_stream("bad_marker", st, 0);

        @(posedge clk); #1;
        scan_start = 1; out_ready = 0;
        @(posedge clk); #1;
        scan_start = 0;
        in_valid = 1; in_data = 8'h12;
        @(posedge clk); #1;
        in_data = 8'hFF;
        @(posedge clk); #1;
        in_data = 8'h00;
        @(posedge clk); #1;
        in_valid = 0;
        chk("mid_reset buffered", 32'(out_valid), 1);
        rst_n = 0;
        #1;
        chk_reset_vals("mid_reset");
        @(posedge clk); #1;
        rst_n = 1;
        ev_got.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_release pulses", 32'(ev_got.size()), 0);
        chk("reset_release out_valid", 32'(out_valid), 0);
        st = '{8'h00};
        run_stream("after_reset", st, 0);

`ifdef RST_CHECK_EN
        st.delete();
        for (int k = 0; k < 9; k++) begin
            st.push_back(8'hFF);
            st.push_back(u8'(8'hD0 + (k % 8)));
        end
        run_stream("rst_sequence", st, 0);
        st = '{8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hD3, 8'hBB};
        run_stream("rst_seq_bad", st, 1);
`endif

        for (int t = 0; t < 25; t++) begin
            gen(st);
            run_stream($sformatf("rand%0d", t), st, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_unstuffer.md
SCAN_UNSTUFFER -- requirements
Module: scan_unstuffer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the output byte counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port scan_start  input  1  one-cycle pulse marking the first entropy-coded byte after the SOS header.
REQ-005 SHALL have port in_data  input  8  raw scan byte.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-008 SHALL have port out_data  output  8  unstuffed entropy byte to the Huffman decoder.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-011 SHALL have port rst_seen  output  1  one-cycle pulse when an RSTn marker (FFD0-FFD7) is consumed.
REQ-012 SHALL have port rst_idx  output  3  n of the last RSTn, held until the next one.
REQ-013 SHALL have port eoi  output  1  one-cycle pulse when FFD9 is consumed.
REQ-014 SHALL have port marker_err  output  1  one-cycle pulse on any other FF-xx marker inside the scan.
REQ-015 SHALL have port scan_done  output  1  level, high in DONE state.
REQ-016 SHALL have port byte_cnt  output  CNT_W  count of bytes delivered on the output handshake since scan_start; wraps modulo 2^CNT_W.

Function
REQ-017 SHALL implement states IDLE, DATA, FF_SEEN, DONE.
REQ-018 IDLE/DONE: in_ready=0; scan_start -> DATA, FIFO flushed, byte_cnt=0.
REQ-019 DATA: accepted byte != 0xFF pushed to output FIFO; 0xFF consumed without push, -> FF_SEEN.
REQ-020 FF_SEEN: 0x00 -> push 0xFF, -> DATA; 0xFF -> fill byte, discarded, stay FF_SEEN.
REQ-021 FF_SEEN: 0xD0-0xD7 -> no push, rst_seen pulse next cycle, rst_idx=low 3 bits, -> DATA.
REQ-022 FF_SEEN: 0xD9 -> no push, eoi pulse next cycle, -> DONE; any other value -> marker_err pulse, -> DONE.
REQ-023 Output path SHALL be a 2-entry FIFO; in_ready = FIFO not full && state in {DATA, FF_SEEN}, with no combinational path from out_ready.
REQ-024 Byte accepted in cycle N SHALL appear on out_data with out_valid in cycle N+1 at the earliest; order preserved.
REQ-025 FIFO full with out_ready=1 in the same cycle SHALL still deassert in_ready (no pass-through).
REQ-026 Bytes already in FIFO on entering DONE SHALL still drain; scan_done high from entry to DONE regardless of FIFO.
REQ-027 scan_start in DATA/FF_SEEN SHALL abort: FIFO flushed, state DATA, byte_cnt=0, in_ready=0 that cycle, no pulse outputs.
REQ-028 byte_cnt increments by 1 per output handshake.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, empty FIFO, out_valid=0, out_data=0, in_ready=0, rst_seen=0, rst_idx=0, eoi=0, marker_err=0, scan_done=0, byte_cnt=0.
REQ-030 Reset mid-scan SHALL discard all buffered bytes; no pulse outputs on reset release.

Configuration
REQ-031 Macro RST_CHECK_EN: when defined, SHALL add output rst_seq_err (1 bit) and a 3-bit expected-index counter, cleared on scan_start, incremented modulo 8 per RSTn; rst_idx != expected -> rst_seq_err one-cycle pulse with rst_seen, counter resyncs to rst_idx+1.
REQ-032 Without RST_CHECK_EN: no rst_seq_err port, no sequence counter; all other behaviour identical.

Verification
REQ-033 scan_start, bytes 12 FF 00 34 FF D9, out_ready=1 -> out 12 FF 34, eoi once, scan_done=1, byte_cnt=3.
REQ-034 Bytes AA FF FF FF D3 BB -> out AA BB, rst_seen once, rst_idx=3; with RST_CHECK_EN rst_seq_err=1 (expected 0).
REQ-035 out_ready=0, 5 non-FF bytes offered -> 2 accepted, in_ready=0; out_ready=1 -> all 5 delivered in order.
REQ-036 Bytes 55 FF C4 -> out 55, marker_err pulse, DONE, further in_valid ignored (in_ready=0).
REQ-037 rst_n low after FF accepted with 2 bytes buffered -> all outputs at reset values; new scan_start then 00 -> outputs 00 (no FF emitted).
REQ-038 With RST_CHECK_EN: FFD0 FFD1 ... FFD7 FFD0 in sequence -> 9 rst_seen pulses, rst_seq_err never asserted.
